delay_line_ctrl: RTL
====================

Name: delay_line_ctrl

Overview:
- Controller and sequencer for a circular delay-line buffer, the same structure the NTT/butterfly pipelines use to realign streams.
- Accepts a runtime delay depth up to SIZE, fills the line, then streams with valid/ready backpressure.
- Drains the remaining words on request and returns to idle.
- Owns the write address, occupancy count and handshake; storage lives in a sub-module.

Parameters:
- WIDTH, 24, data word width in bits.
- SIZE, 128, maximum delay depth (storage words); must be >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cfg_valid  input  1  depth configuration request.
- cfg_depth  input  $clog2(SIZE+1)  requested delay in words.
- cfg_ready  output  1  high only in IDLE.
- cfg_err  output  1  one-cycle pulse when a config request is rejected.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid && in_ready.
- in_data  input  WIDTH  input word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream can take the output word.
- out_data  output  WIDTH  delayed word.
- drain  input  1  stop input and flush the remaining words out.
- flush  input  1  abort: discard contents, return to IDLE.
- busy  output  1  state != IDLE.
- level  output  $clog2(SIZE+1)  number of valid words held.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, addr=0, cnt=0, depth_q=0. Outputs: cfg_ready=1, cfg_err=0, in_ready=0, out_valid=0, busy=0, level=0. Memory is not reset; out_data is don't-care while out_valid=0.
- Delay contract: the n-th accepted input word appears as output word n+depth. Output order is preserved exactly across stalls.
- Storage: write-through-address. out_data=mem[addr] (combinational read). A write of in_data at addr is registered on an accepted transfer. addr advances by 1 and wraps to 0 after depth_q-1.
- IDLE:
  - cfg_ready=1, in_ready=0, out_valid=0.
  - cfg_valid with 1 <= cfg_depth <= SIZE: latch depth_q, addr=0, cnt=0, go to FILL.
  - cfg_valid with an illegal depth: stay in IDLE and pulse cfg_err for 1 cycle.
- FILL:
  - in_ready=1, out_valid=0.
  - Each accept writes the word, advances addr and increments cnt.
  - When the accept makes cnt==depth_q, go to STREAM.
- STREAM:
  - out_valid=in_valid, in_ready=out_ready.
  - fire = in_valid && out_ready: emits mem[addr] and writes in_data at the same addr in the same cycle. addr advances; cnt holds at depth_q.
  - drain=1: go to DRAIN next cycle. A fire in that same cycle still completes.
- DRAIN:
  - in_ready=0, out_valid=1.
  - Each out_ready advances addr and decrements cnt.
  - When the beat makes cnt==0, go to IDLE.
  - drain is ignored in all states other than STREAM.
- flush:
  - Any state: next cycle state=IDLE, addr=0, cnt=0.
  - Priority is rst > flush > cfg/drain/data.
  - A transfer handshaking in the flush cycle is discarded.
- level = cnt. Width rule: cnt never exceeds depth_q <= SIZE.
- Stall: out_ready=0 in STREAM holds addr, cnt and out_data unchanged.

Optional Feature:
- Macro: DELAY_LINE_CTRL_BYPASS_EN.
- Defined:
  - cfg_depth=0 is legal and goes IDLE->STREAM directly.
  - In STREAM with depth_q=0: out_data=in_data, out_valid=in_valid, in_ready=out_ready (zero latency, no memory writes).
  - drain goes straight to IDLE; level=0.
- Not defined: cfg_depth=0 is rejected with cfg_err, and the bypass mux is absent.

Decomposition:
- Package delay_line_pkg: state enum (IDLE, FILL, STREAM, DRAIN) as a 2-bit typedef; localparam-style function for the depth/count width ($clog2(SIZE+1)).
- Sub-module delay_line_mem (WIDTH, SIZE): one write port (addr, we, wdata), combinational read at the same addr. The controller drives we = FILL accept or STREAM fire.

Test Plan:
- Reset, then cfg_depth=4 with inputs 1..10 and out_ready=1 -> outputs 1..6 on the beats where inputs 5..10 are accepted. level goes 0,1,2,3,4 and then holds 4.
- After the above, assert drain -> outputs 7,8,9,10 with in_ready=0. level goes 3,2,1,0; busy drops and cfg_ready=1.
- cfg_depth=SIZE (128), then toggle out_ready every other cycle -> exact n+128 ordering; addr wraps 127->0 with no loss or duplication.
- cfg_depth=SIZE+1, and separately cfg_depth=0 without the macro -> cfg_err single pulse, state stays IDLE. With the macro, depth 0 gives out_data==in_data in the same cycle.
- flush mid-FILL (cnt=2) and mid-STREAM -> next cycle IDLE, level=0. A new cfg_depth=3 restarts cleanly: the first output equals the first new input, with no stale data.
- rst asserted in DRAIN while out_ready=1 -> next cycle all outputs at their reset values. drain/flush/cfg asserted together with rst are ignored.

Source files
------------

// File: rtl/delay_line_pkg.sv
// -----------------------------------------------------------------------------
// delay_line_pkg
// Shared types and helpers for the delay-line controller.
//   state_t   : controller state encoding (IDLE, FILL, STREAM, DRAIN).
//   cnt_width : width of the depth / occupancy fields for a given SIZE,
//               wide enough to hold the value SIZE itself.
// -----------------------------------------------------------------------------
package delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/delay_line_mem.sv
// -----------------------------------------------------------------------------
// delay_line_mem
// Single-port circular storage for the delay line: one registered write port
// and a combinational read at the same address, so a word can be read out and
// replaced in the same cycle.
// Ports:
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : word to write
//   rdata : mem[addr], combinational
// -----------------------------------------------------------------------------
module delay_line_mem #(
    parameter int WIDTH = 24,
    parameter int SIZE  = 128
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [$clog2(SIZE)-1:0] addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem_r [SIZE];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl
// Controller/sequencer for a circular delay line. A runtime depth (1..SIZE) is
// configured in IDLE, the line is filled, then words stream through with
// valid/ready backpressure so that accepted word n leaves as output word
// n+depth. drain flushes the held words out; flush aborts to IDLE.
//
// Optional build macro DELAY_LINE_CTRL_BYPASS_EN: depth 0 becomes legal and
// selects a zero-latency pass-through (out_data = in_data) in STREAM.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cfg_valid, cfg_depth  : depth configuration request (accepted in IDLE)
//   cfg_ready             : high only in IDLE
//   cfg_err               : one-cycle pulse after a rejected config request
//   in_valid/in_ready/in_data    : input stream
//   out_valid/out_ready/out_data : delayed output stream
//   drain                 : in STREAM, stop input and empty the line
//   flush                 : abort, discard contents, return to IDLE
//   busy                  : state != IDLE
//   level                 : number of valid words held
// -----------------------------------------------------------------------------
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SIZE  = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    input  logic [$clog2(SIZE+1)-1:0] cfg_depth,
    output logic                      cfg_ready,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      drain,
    input  logic                      flush,
    output logic                      busy,
    output logic [$clog2(SIZE+1)-1:0] level
);

    localparam int DW = cnt_width(SIZE);
    localparam int AW = $clog2(SIZE);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   addr_r;
    logic [AW-1:0]   addr_nxt_s;
    logic [AW-1:0]   addr_inc_s;
    logic [DW-1:0]   cnt_r;
    logic [DW-1:0]   cnt_nxt_s;
    logic [DW-1:0]   depth_r;
    logic [DW-1:0]   depth_nxt_s;
    logic            cfg_err_r;
    logic            cfg_err_nxt_s;
    logic            cfg_ok_s;
    logic            bypass_s;
    logic            we_s;
    logic            cfg_ready_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic [WIDTH-1:0] rdata_s;

`ifdef DELAY_LINE_CTRL_BYPASS_EN
    assign cfg_ok_s = (cfg_depth <= DW'(SIZE));
    assign bypass_s = (state_r == STREAM) && (depth_r == {DW{1'b0}});
`else
    assign cfg_ok_s = (cfg_depth != {DW{1'b0}}) && (cfg_depth <= DW'(SIZE));
    assign bypass_s = 1'b0;
`endif

    // Circular address: wrap to 0 after the last slot of the configured depth.
    assign addr_inc_s = (DW'(addr_r) == (depth_r - DW'(1))) ? {AW{1'b0}}
                                                            : (addr_r + AW'(1));

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_nxt_s   = state_r;
        addr_nxt_s    = addr_r;
        cnt_nxt_s     = cnt_r;
        depth_nxt_s   = depth_r;
        cfg_err_nxt_s = 1'b0;
        we_s          = 1'b0;
        cfg_ready_s   = 1'b0;
        in_ready_s    = 1'b0;
        out_valid_s   = 1'b0;

        case (state_r)
            IDLE: begin
                cfg_ready_s = 1'b1;
                if (cfg_valid) begin
                    if (cfg_ok_s) begin
                        depth_nxt_s = cfg_depth;
                        addr_nxt_s  = {AW{1'b0}};
                        cnt_nxt_s   = {DW{1'b0}};
                        // Depth 0 is only reachable when bypass is built in.
                        state_nxt_s = (cfg_depth == {DW{1'b0}}) ? STREAM : FILL;
                    end else begin
                        cfg_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    we_s       = 1'b1;
                    addr_nxt_s = addr_inc_s;
                    cnt_nxt_s  = cnt_r + DW'(1);
                    if ((cnt_r + DW'(1)) == depth_r) begin
                        state_nxt_s = STREAM;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            STREAM: begin
                in_ready_s  = out_ready;
                out_valid_s = in_valid;
                // A fire reads the oldest word and overwrites it with the new one.
                if (in_valid && out_ready && !bypass_s) begin
                    we_s       = 1'b1;
                    addr_nxt_s = addr_inc_s;
                end else begin
                    addr_nxt_s = addr_r;
                end
                if (drain) begin
                    state_nxt_s = bypass_s ? IDLE : DRAIN;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DRAIN: begin
                out_valid_s = 1'b1;
                if (out_ready) begin
                    addr_nxt_s = addr_inc_s;
                    cnt_nxt_s  = cnt_r - DW'(1);
                    if (cnt_r == DW'(1)) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // flush overrides everything except rst; any handshake this cycle is dropped.
        if (flush) begin
            state_nxt_s   = IDLE;
            addr_nxt_s    = {AW{1'b0}};
            cnt_nxt_s     = {DW{1'b0}};
            depth_nxt_s   = depth_r;
            cfg_err_nxt_s = 1'b0;
            we_s          = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            addr_r    <= {AW{1'b0}};
            cnt_r     <= {DW{1'b0}};
            depth_r   <= {DW{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            addr_r    <= addr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            depth_r   <= depth_nxt_s;
            cfg_err_r <= cfg_err_nxt_s;
        end
    end

    delay_line_mem #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (we_s && !rst),
        .addr  (addr_r),
        .wdata (in_data),
        .rdata (rdata_s)
    );

    assign cfg_ready = cfg_ready_s;
    assign cfg_err   = cfg_err_r;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = bypass_s ? in_data : rdata_s;
    assign busy      = (state_r != IDLE);
    assign level     = cnt_r;

endmodule
